// File: rtl/mole_pkg.sv
// mole_pkg: shared types and constants for the whack-a-mole round sequencer.
//   state_t     - sequencer states (idle, gap between moles, mole up, game over)
//   LFSR_SEED   - reset value of the hole-selection LFSR
//   LFSR_TAPS   - feedback mask for x^8+x^6+x^5+x^4+1 (left-shifting Fibonacci form)
//   DEF_*       - default timing / game constants used as parameter defaults
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_UP,
        ST_OVER
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEF_NUM_HOLES     = 8;
    localparam int DEF_IDX_W         = 3;
    localparam int DEF_GAP_TICKS     = 300;
    localparam int DEF_DWELL_INIT    = 1000;
    localparam int DEF_DWELL_STEP    = 50;
    localparam int DEF_DWELL_MIN     = 200;
    localparam int DEF_LIVES         = 3;
    localparam int DEF_LEVEL_UP_HITS = 5;
    localparam int DEF_SCORE_W       = 8;

    // One step of the LFSR: shift left, feed the parity of the tapped bits into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_scheduler_lfsr8.sv
// lfsr8: 8-bit maximal-length Fibonacci LFSR used to pick the next hole.
//   master_clk - clock
//   rst_n      - async active-low reset, loads LFSR_SEED
//   en         - advance one step this cycle
//   state      - current LFSR contents (never all-zeros from a nonzero seed)
module lfsr8 import mole_pkg::*; (
    input  logic       master_clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] state
);

    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n)  state <= LFSR_SEED;
        else if (en) state <= lfsr_next(state);
    end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: round sequencer for the whack-a-mole game.
//   master_clk  - system clock          rst_n      - async active-low reset
//   tick        - 1-cycle timebase      start      - 1-cycle start/restart
//   btn_valid   - 1-cycle button press  btn_idx    - hole of the pressed button
//   mole_onehot - lit hole (0 = none)   score      - saturating hit count
//   lives_left  - remaining lives       level      - level, saturates at 15
//   game_over   - high in OVER          hit_pulse / miss_pulse - 1-cycle events
// All outputs are registered; each reacts on the edge after the qualifying input.
module mole_scheduler import mole_pkg::*; #(
    parameter int NUM_HOLES     = DEF_NUM_HOLES,
    parameter int IDX_W         = DEF_IDX_W,
    parameter int GAP_TICKS     = DEF_GAP_TICKS,
    parameter int DWELL_INIT    = DEF_DWELL_INIT,
    parameter int DWELL_STEP    = DEF_DWELL_STEP,
    parameter int DWELL_MIN     = DEF_DWELL_MIN,
    parameter int LIVES         = DEF_LIVES,
    parameter int LEVEL_UP_HITS = DEF_LEVEL_UP_HITS,
    parameter int SCORE_W       = DEF_SCORE_W
) (
    input  logic                 master_clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 btn_valid,
    input  logic [IDX_W-1:0]     btn_idx,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           lives_left,
    output logic [3:0]           level,
    output logic                 game_over,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam logic [15:0]          GAP_W       = 16'(GAP_TICKS);
    localparam logic [15:0]          DWELL_INIT_W = 16'(DWELL_INIT);
    localparam logic [15:0]          DWELL_STEP_W = 16'(DWELL_STEP);
    localparam logic [15:0]          DWELL_MIN_W  = 16'(DWELL_MIN);
    // Below this the step would cross the floor, so clamp instead of subtracting.
    localparam logic [15:0]          DWELL_CLAMP = 16'(DWELL_MIN + DWELL_STEP);
    localparam logic [1:0]           LIVES_W     = 2'(LIVES);
    localparam logic [7:0]           HITS_LAST   = 8'(LEVEL_UP_HITS - 1);
    localparam logic [NUM_HOLES-1:0] ONE_HOT0    = NUM_HOLES'(1);

    state_t           state;
    logic [15:0]      timer;
    logic [15:0]      dwell;
    logic [7:0]       hit_cnt;
    logic [IDX_W-1:0] cur_idx;   // hole of the current / most recent mole
    logic [IDX_W-1:0] next_idx;
    logic [7:0]       lfsr_q;
    logic             timer_expire;
    logic             good_hit;
    logic             unused_lfsr_bits;

    // Free-running: the cycle at which a round starts depends on player timing.
    lfsr8 u_lfsr (
        .master_clk (master_clk),
        .rst_n      (rst_n),
        .en         (1'b1),
        .state      (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[7:IDX_W];

    // Never show the same hole twice in a row; the index wraps mod NUM_HOLES.
    always_comb begin
        next_idx = lfsr_q[IDX_W-1:0];
        if (next_idx == cur_idx) next_idx = next_idx + 1'b1;
    end

    assign timer_expire = tick && (timer == 16'd1);
    assign good_hit     = btn_valid && (btn_idx == cur_idx);

    always_ff @(posedge master_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            dwell       <= DWELL_INIT_W;
            hit_cnt     <= '0;
            cur_idx     <= '0;
            mole_onehot <= '0;
            score       <= '0;
            lives_left  <= LIVES_W;
            level       <= '0;
            game_over   <= 1'b0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;

            case (state)
                // Both idle and game-over restart the same way; a tick in the
                // start cycle is not counted against the first gap.
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        score      <= '0;
                        level      <= '0;
                        hit_cnt    <= '0;
                        lives_left <= LIVES_W;
                        dwell      <= DWELL_INIT_W;
                        timer      <= GAP_W;
                        game_over  <= 1'b0;
                        state      <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (timer_expire) begin
                        cur_idx     <= next_idx;
                        mole_onehot <= ONE_HOT0 << next_idx;
                        timer       <= dwell;
                        state       <= ST_UP;
                    end else if (tick) begin
                        timer <= timer - 16'd1;
                    end
                end

                ST_UP: begin
                    // A correct press beats an expiry tick in the same cycle.
                    if (good_hit) begin
                        hit_pulse   <= 1'b1;
                        mole_onehot <= '0;
                        timer       <= GAP_W;
                        state       <= ST_GAP;
                        if (score != '1) score <= score + 1'b1;
                        if (hit_cnt == HITS_LAST) begin
                            hit_cnt <= '0;
                            if (level != 4'hF) level <= level + 4'd1;
                            dwell <= (dwell < DWELL_CLAMP) ? DWELL_MIN_W
                                                           : dwell - DWELL_STEP_W;
                        end else begin
                            hit_cnt <= hit_cnt + 8'd1;
                        end
                    end else if (timer_expire) begin
                        miss_pulse  <= 1'b1;
                        mole_onehot <= '0;
                        lives_left  <= lives_left - 2'd1;
                        if (lives_left == 2'd1) begin
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else begin
                            timer <= GAP_W;
                            state <= ST_GAP;
                        end
                    end else if (tick) begin
                        timer <= timer - 16'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler with a scoreboard: a game-rules model
// pushes the expected outputs every clock, a monitor pops and compares them.
module tb_mole_scheduler;

    localparam int NH = 8, IW = 3, SW = 8;
    localparam int GAP = 2, DW_INIT = 4, DW_STEP = 1, DW_MIN = 2;
    localparam int NLIVES = 3, LUP = 2;
    localparam int PH_IDLE = 0, PH_GAP = 1, PH_UP = 2, PH_OVER = 3;

    logic          master_clk = 1'b0;
    logic          rst_n      = 1'b0;
    logic          tick       = 1'b0;
    logic          start      = 1'b0;
    logic          btn_valid  = 1'b0;
    logic [IW-1:0] btn_idx    = '0;
    logic [NH-1:0] mole_onehot;
    logic [SW-1:0] score;
    logic [1:0]    lives_left;
    logic [3:0]    level;
    logic          game_over, hit_pulse, miss_pulse;

    mole_scheduler #(
        .NUM_HOLES(NH), .IDX_W(IW), .GAP_TICKS(GAP), .DWELL_INIT(DW_INIT),
        .DWELL_STEP(DW_STEP), .DWELL_MIN(DW_MIN), .LIVES(NLIVES),
        .LEVEL_UP_HITS(LUP), .SCORE_W(SW)
    ) dut (
        .master_clk(master_clk), .rst_n(rst_n), .tick(tick), .start(start),
        .btn_valid(btn_valid), .btn_idx(btn_idx), .mole_onehot(mole_onehot),
        .score(score), .lives_left(lives_left), .level(level),
        .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 master_clk = ~master_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- game-rules reference model ----------------
    typedef struct packed {
        logic [NH-1:0] mask;
        logic [SW-1:0] score;
        logic [1:0]    lives;
        logic [3:0]    level;
        logic          over;
        logic          hit;
        logic          miss;
    } exp_t;

    exp_t expq[$];

    int       m_phase, m_left, m_score, m_lives, m_level, m_dwell, m_hits, m_idx;
    bit       m_hit, m_miss;
    bit [7:0] m_lfsr;

    task automatic model_reset();
        m_phase = PH_IDLE; m_left = 0; m_score = 0; m_lives = NLIVES; m_level = 0;
        m_dwell = DW_INIT; m_hits = 0; m_idx = 0; m_hit = 0; m_miss = 0;
        m_lfsr = 8'hA5;
    endtask

    task automatic model_step(input bit st, input bit tk, input bit bv, input int bi);
        int pick;
        m_hit = 0; m_miss = 0;
        case (m_phase)
            PH_IDLE, PH_OVER: if (st) begin
                m_score = 0; m_level = 0; m_hits = 0; m_lives = NLIVES;
                m_dwell = DW_INIT; m_left = GAP; m_phase = PH_GAP;
            end
            PH_GAP: if (tk) begin
                m_left--;
                if (m_left == 0) begin
                    pick = int'(m_lfsr) % NH;
                    if (pick == m_idx) pick = (pick + 1) % NH;
                    m_idx = pick; m_left = m_dwell; m_phase = PH_UP;
                end
            end
            PH_UP: begin
                if (bv && bi == m_idx) begin
                    m_hit = 1;
                    if (m_score < (1 << SW) - 1) m_score++;
                    m_hits++;
                    if (m_hits == LUP) begin
                        m_hits = 0;
                        if (m_level < 15) m_level++;
                        m_dwell = (m_dwell - DW_STEP < DW_MIN) ? DW_MIN : m_dwell - DW_STEP;
                    end
                    m_left = GAP; m_phase = PH_GAP;
                end else if (tk) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_miss = 1; m_lives--;
                        if (m_lives == 0) m_phase = PH_OVER;
                        else begin m_left = GAP; m_phase = PH_GAP; end
                    end
                end
            end
            default: ;
        endcase
        // x^8+x^6+x^5+x^4+1, one step per clock
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    always @(posedge master_clk) begin
        exp_t e;
        if (!rst_n) model_reset();
        else        model_step(start, tick, btn_valid, int'(btn_idx));
        e.mask  = (m_phase == PH_UP) ? NH'(1 << m_idx) : '0;
        e.score = SW'(m_score);
        e.lives = 2'(m_lives);
        e.level = 4'(m_level);
        e.over  = (m_phase == PH_OVER);
        e.hit   = m_hit;
        e.miss  = m_miss;
        expq.push_back(e);
    end

    // An async reset discards the expectation of the interrupted cycle.
    always @(negedge rst_n) expq.delete();

    // ---------------- monitor ----------------
    int            rounds    = 0;
    int            last_idx  = 0;
    bit            have_last = 0;
    logic [NH-1:0] prev_mask = '0;

    always @(negedge master_clk) begin
        exp_t e, g;
        int   idx;
        if (!rst_n) have_last = 0;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g.mask = mole_onehot; g.score = score; g.lives = lives_left; g.level = level;
            g.over = game_over; g.hit = hit_pulse; g.miss = miss_pulse;
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got mask=%h score=%0d lives=%0d level=%0d over=%b hit=%b miss=%b, expected mask=%h score=%0d lives=%0d level=%0d over=%b hit=%b miss=%b",
                         $time, g.mask, g.score, g.lives, g.level, g.over, g.hit, g.miss,
                         e.mask, e.score, e.lives, e.level, e.over, e.hit, e.miss);
            end
        end
        check("pulse_excl_onehot", int'(hit_pulse && miss_pulse) + int'($countones(mole_onehot) > 1), 0);
        if (rst_n && mole_onehot != '0 && prev_mask == '0) begin
            idx = 0;
            for (int i = 0; i < NH; i++) if (mole_onehot[i]) idx = i;
            if (have_last) check("idx_no_repeat", int'(idx == last_idx), 0);
            last_idx = idx; have_last = 1; rounds++;
        end
        prev_mask = mole_onehot;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit t, input bit s, input bit b, input int i);
        tick = t; start = s; btn_valid = b; btn_idx = IW'(i);
        @(posedge master_clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  misses, cyc, r, lives_b, score_b;
        bit  tk;
        repeat (3) @(posedge master_clk);
        #1 rst_n = 1'b1;
        check("reset_lives", lives_left, NLIVES);
        check("reset_mask", mole_onehot, 0);
        check("reset_over", game_over, 0);

        // No presses at all: three timeouts end the game.
        drive(0, 1, 0, 0);
        misses = 0;
        for (cyc = 0; cyc < 400 && !game_over; cyc++) begin
            drive(cyc % 3 == 2, 0, 0, 0);
            if (miss_pulse) misses++;
        end
        check("game_over_reached", game_over, 1);
        check("miss_count", misses, 3);
        check("over_lives", lives_left, 0);
        check("over_mask", mole_onehot, 0);
        drive(0, 1, 0, 0);
        check("restart_lives", lives_left, NLIVES);
        check("restart_score", score, 0);
        check("restart_over", game_over, 0);

        // Steady ticks, hits / wrong presses / hit on the expiry tick.
        for (cyc = 0; cyc < 400; cyc++) begin
            tk = (cyc % 3 == 2);
            r  = $urandom_range(0, 9);
            if (m_phase == PH_OVER) drive(0, 1, 0, 0);
            else if (m_phase == PH_UP && tk && m_left == 1 && r < 6) begin
                lives_b = m_lives;
                drive(1, 0, 1, m_idx);
                check("coincide_hit", hit_pulse, 1);
                check("coincide_miss", miss_pulse, 0);
                check("coincide_lives", lives_left, lives_b);
            end else if (m_phase == PH_UP && r == 0) begin
                score_b = m_score;
                drive(tk, 0, 1, (m_idx + 1 + int'($urandom_range(0, NH - 2))) % NH);
                check("wrong_no_hit", hit_pulse, 0);
                check("wrong_score", score, score_b);
            end else if (m_phase == PH_UP && r == 1) drive(tk, 0, 1, m_idx);
            else drive(tk, 0, 0, 0);
        end

        // Fully random traffic, including stray starts and presses.
        for (cyc = 0; cyc < 4000 && rounds < 60; cyc++) begin
            r = $urandom_range(0, 19);
            if (m_phase == PH_UP && r < 4)
                drive($urandom_range(0, 1) == 1, r == 0, 1, (r == 3) ? $urandom_range(0, NH - 1) : m_idx);
            else
                drive($urandom_range(0, 1) == 1,
                      r == 5 || (m_phase == PH_OVER && r < 8),
                      r == 6, $urandom_range(0, NH - 1));
        end
        check("rounds_50", int'(rounds >= 50), 1);

        // Async reset while a mole is up.
        if (m_phase != PH_GAP && m_phase != PH_UP) drive(0, 1, 0, 0);
        for (cyc = 0; cyc < 200 && m_phase != PH_UP; cyc++) drive(1, 0, 0, 0);
        check("reached_up", int'(m_phase == PH_UP), 1);
        check("up_mask_lit", int'(mole_onehot != '0), 1);
        #2 rst_n = 1'b0;
        tick = 0; start = 0; btn_valid = 0;
        #1;
        check("arst_mask", mole_onehot, 0);
        check("arst_score", score, 0);
        check("arst_lives", lives_left, NLIVES);
        check("arst_level", level, 0);
        check("arst_over", game_over, 0);
        check("arst_pulses", int'(hit_pulse | miss_pulse), 0);
        @(posedge master_clk); #1 rst_n = 1'b1;
        // Back in idle: ticks alone never raise a mole.
        for (cyc = 0; cyc < 10; cyc++) drive(1, 0, 0, 0);
        check("idle_no_mole", mole_onehot, 0);
        drive(1, 1, 0, 0);
        for (cyc = 0; cyc < 40; cyc++) drive(cyc % 2 == 0, 0, m_phase == PH_UP, m_idx);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
